// File: rtl/mips_program_loader.sv
// Symbolic-instruction encoder feeding a small FIFO that streams MIPS words
// into instruction memory from a programmable base address.
module mips_program_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_in_sel,
    input  logic [4:0]        i_in_rs,
    input  logic [4:0]        i_in_rt,
    input  logic [4:0]        i_in_rd,
    input  logic [25:0]       i_in_imm,
    input  logic              i_in_last,
    output logic              o_imem_we,
    input  logic              i_imem_ready,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_count
);
    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [3:0]  SEL_ILL  = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_state_nx;
    logic [31:0]       r_mem [DEPTH];
    logic [PW:0]       r_wptr, r_rptr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_wcount;
    logic              r_err, r_last_seen;

    logic [PW:0] w_count, w_count_nx;
    logic        w_full, w_empty, w_in_ready, w_xfer, w_illegal, w_push;
    logic        w_we, w_commit, w_start, w_last_nx;
    logic [31:0] w_enc;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count    = r_wptr - r_rptr;
    assign w_full     = (w_count == FULL_CNT);
    assign w_empty    = (w_count == '0);
    assign w_in_ready = (r_state == S_RUN) && !w_full && !r_last_seen;
    assign w_xfer     = i_in_valid && w_in_ready;
    assign w_illegal  = (i_in_sel == SEL_ILL);
    assign w_push     = w_xfer && !w_illegal;
    assign w_we       = (r_state == S_RUN) && !w_empty;
    assign w_commit   = w_we && i_imem_ready;
    assign w_start    = i_start && (r_state != S_RUN);
    assign w_last_nx  = r_last_seen || (w_xfer && i_in_last);
    assign w_count_nx = w_count + (PW+1)'(w_push) - (PW+1)'(w_commit);

    always_comb begin
        w_enc = '0;
        case (i_in_sel)
            4'd1:  w_enc = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'h00, 6'h20};
            4'd2:  w_enc = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'h00, 6'h22};
            4'd3:  w_enc = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'h00, 6'h2A};
            4'd4:  w_enc = {6'h00, i_in_rs, i_in_rt, i_in_rd, 5'h00, 6'h27};
            4'd5:  w_enc = {6'h08, i_in_rs, i_in_rt, i_in_imm[15:0]};
            4'd6:  w_enc = {6'h0C, i_in_rs, i_in_rt, i_in_imm[15:0]};
            4'd7:  w_enc = {6'h0F, 5'h00,   i_in_rt, i_in_imm[15:0]};
            4'd8:  w_enc = {6'h23, i_in_rs, i_in_rt, i_in_imm[15:0]};
            4'd9:  w_enc = {6'h2B, i_in_rs, i_in_rt, i_in_imm[15:0]};
            4'd10: w_enc = {6'h04, i_in_rs, i_in_rt, i_in_imm[15:0]};
            4'd11: w_enc = {6'h05, i_in_rs, i_in_rt, i_in_imm[15:0]};
            4'd12: w_enc = {6'h02, i_in_imm};
            4'd13: w_enc = {6'h00, i_in_rs, 15'h0000, 6'h08};
            4'd14: w_enc = {6'h03, i_in_imm};
            default: w_enc = '0;
        endcase
    end

    // Look ahead on next-cycle occupancy so done rises the cycle after the final commit.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nx = S_RUN;
            S_RUN:   if (w_last_nx && (w_count_nx == '0)) w_state_nx = S_DONE;
            S_DONE:  if (i_start) w_state_nx = S_RUN;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= w_enc;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_addr      <= '0;
            r_wcount    <= '0;
            r_err       <= 1'b0;
            r_last_seen <= 1'b0;
        end else if (w_start) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_addr      <= i_base_addr;
            r_wcount    <= '0;
            r_err       <= 1'b0;
            r_last_seen <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_commit) begin
                r_rptr   <= r_rptr + 1'b1;
                r_addr   <= r_addr + 1'b1;
                r_wcount <= r_wcount + 1'b1;
            end
            if (w_xfer && w_illegal) r_err <= 1'b1;
            if (w_xfer && i_in_last) r_last_seen <= 1'b1;
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_imem_we    = w_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = w_empty ? 32'h0 : r_mem[r_rptr[PW-1:0]];
    assign o_done       = (r_state == S_DONE);
    assign o_err        = r_err;
    assign o_word_count = r_wcount;
endmodule
